eight_bit_adder: RTL and testbench
==================================

# eight_bit_adder

Registered 8-bit binary adder with carry-in, built on a ripple-carry chain of full-adder cells. Operands are added combinationally and the result, carry-out and status flags are captured in an output register one clock after a valid input. It is the basic arithmetic leaf used by wider datapath blocks, such as cascaded adders and accumulators, that need a clocked, flag-producing add stage.

## Interface
- WIDTH, 8, operand and sum width. Only 8 needs to be supported, but the chain must be written generically.
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, unsigned; also interpreted as two's complement for the overflow flag.
- B  input  WIDTH  operand B, with the same interpretation as A.
- Cin  input  1  carry into bit 0.
- in_valid  input  1  when high, A, B and Cin are sampled at the next rising clk.
- sum  output  WIDTH  registered (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  registered carry out of the MSB.
- overflow  output  1  registered signed overflow.
- zero  output  1  registered flag, set when sum == 0.
- out_valid  output  1  registered copy of in_valid.

## Operation
- Datapath core:
  - WIDTH full-adder cells in a ripple chain.
  - Cell i computes s[i] = a^b^c and c[i+1] = ab | c(a^b), with c[0] = Cin.
  - The core is purely combinational.
- Arithmetic:
  - The full result {Cout, sum} = A + B + Cin, which is exact and WIDTH+1 bits wide.
  - The maximum is 255 + 255 + 1 = 511, giving sum = 255 and Cout = 1.
- overflow = c[WIDTH] ^ c[WIDTH-1], meaning the signed result does not fit in WIDTH bits.
- zero is computed from the next sum value, not from Cout. For example, 128 + 128 gives sum = 0, Cout = 1 and zero = 1.
- On a rising clk with in_valid = 1:
  - sum, Cout, overflow and zero load from the core.
  - out_valid is set to 1.
- On a rising clk with in_valid = 0:
  - sum, Cout, overflow and zero hold their previous values.
  - out_valid is cleared to 0.
- There is no backpressure. A result is available for exactly the one cycle after its input; downstream logic must capture it when out_valid = 1.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one add per cycle, and back-to-back valid inputs are allowed.
- Reset is asserted asynchronously, on rst_n falling, with no clock needed:
  - sum = 0, Cout = 0, overflow = 0, zero = 0, out_valid = 0.
- Reset release is synchronous to clk. The first capture occurs at the first rising edge with rst_n = 1 and in_valid = 1.
- Reset mid-operation: any in-flight result is discarded and the outputs show the reset values immediately.
- All outputs change only on a clk edge or on reset; there are no combinational paths from inputs to outputs.
- Inputs must be stable for setup and hold around the rising clk edge.

## Test plan
- Reset: drive rst_n low between clock edges -> outputs clear at once: sum = 0, Cout = 0, overflow = 0, zero = 0, out_valid = 0.
- Zero operands: A = 0, B = 0, Cin = 0, in_valid = 1 -> the next cycle gives sum = 0, Cout = 0, zero = 1, overflow = 0, out_valid = 1.
- Plain add: A = 3, B = 64, Cin = 0 -> sum = 67, Cout = 0, zero = 0, overflow = 0.
- Signed overflow: A = 99, B = 50, Cin = 1 -> sum = 150, Cout = 0, overflow = 1.
- Maximum: A = 255, B = 255, Cin = 1 -> sum = 255, Cout = 1, overflow = 0. Then A = 128, B = 128, Cin = 0 -> sum = 0, Cout = 1, zero = 1, overflow = 1.
- Hold and random:
  - Drop in_valid for 3 cycles -> outputs hold the last result and out_valid = 0.
  - Then apply 1000 random back-to-back A/B/Cin values -> each {Cout, sum} equals A + B + Cin of the input one cycle earlier.

Source files
------------

// File: rtl/eight_bit_adder.sv
// eight_bit_adder: registered WIDTH-bit ripple-carry adder with carry-in and status flags.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   A, B      - operands (unsigned, also read as two's complement for overflow)
//   Cin       - carry into bit 0
//   in_valid  - A/B/Cin are captured on the next rising clk when high
//   sum       - registered (A + B + Cin) mod 2^WIDTH
//   Cout      - registered carry out of the MSB
//   overflow  - registered signed overflow
//   zero      - registered flag, sum == 0
//   out_valid - registered copy of in_valid
module eight_bit_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  // Combinational ripple-carry core
  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] sum_c;

  assign carry_c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_c[i]       = A[i] ^ B[i] ^ carry_c[i];
    assign carry_c[i+1]   = (A[i] & B[i]) | (carry_c[i] & (A[i] ^ B[i]));
  end

  // Output register state
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             vld_q, vld_d;

  // Next-state: load on valid input, otherwise hold results and drop valid
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    vld_d  = in_valid;
    if (in_valid) begin
      sum_d  = sum_c;
      cout_d = carry_c[WIDTH];
      // Signed overflow: carry into and out of the sign bit disagree
      ovf_d  = carry_c[WIDTH] ^ carry_c[WIDTH-1];
      // Flag tracks the truncated sum, independent of Cout
      zero_d = (sum_c == '0);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      vld_q  <= vld_d;
    end
  end

  assign sum       = sum_q;
  assign Cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_eight_bit_adder.sv
// tb_eight_bit_adder: directed-vector and random self-checking bench for eight_bit_adder.
module tb_eight_bit_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         Cout;
  logic         overflow;
  logic         zero;
  logic         out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  eight_bit_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .Cout      (Cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  vec_t vecs[12];

  // Compare all outputs as one packed word {out_valid, zero, overflow, Cout, sum}
  task automatic check(input string name, input logic [W-1:0] e_sum, input logic e_cout,
                       input logic e_ovf, input logic e_zero, input logic e_vld);
    logic [W+3:0] act;
    logic [W+3:0] exp;
    act = {out_valid, zero, overflow, Cout, sum};
    exp = {e_vld, e_zero, e_ovf, e_cout, e_sum};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got vld=%b zero=%b ovf=%b cout=%b sum=%0d, want vld=%b zero=%b ovf=%b cout=%b sum=%0d",
               name, act[W+3], act[W+2], act[W+1], act[W], act[W-1:0],
               exp[W+3], exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, last_sum;
    logic         rc, last_cout, last_ovf, last_zero;
    logic [W:0]   full;

    //           a     b    cin  sum  cout ovf zero
    vecs[0]  = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'd3,   8'd64,  1'b0, 8'd67,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'd99,  8'd50,  1'b1, 8'd150, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1};
    vecs[5]  = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0, 1'b1};
    vecs[7]  = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0, 1'b1};
    vecs[8]  = '{8'd127, 8'd0,   1'b1, 8'd128, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'd128, 8'd255, 1'b0, 8'd127, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{8'd85,  8'd170, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b0;
    #2;
    check("reset_initial", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release reset between edges, then stream the table back to back
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].cin; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_cout,
            vecs[i].e_ovf, vecs[i].e_zero, 1'b1);
    end

    // Hold: inputs change but are not valid; last result must persist
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 8'd1 + 8'(i); B = 8'd7; Cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d", i), 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Random back-to-back adds, checked one cycle later against a reference model
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rc = 1'($urandom_range(1));
      A = ra; B = rb; Cin = rc; in_valid = 1'b1;
      full = 9'(ra) + 9'(rb) + 9'(rc);
      last_sum  = full[W-1:0];
      last_cout = full[W];
      last_ovf  = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      last_zero = (full[W-1:0] == 8'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rand%0d", i), last_sum, last_cout, last_ovf, last_zero, 1'b1);
    end

    // Mid-operation reset: capture a known nonzero result, then reset between edges
    A = 8'd3; B = 8'd64; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pre_reset", 8'd67, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("reset_held_valid_in", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release with no valid input: nothing captured
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // First capture after reset
    A = 8'd99; B = 8'd50; Cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_first", 8'd150, 1'b0, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_drop", 8'd150, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
